// File: rtl/isa_record_packer.sv
// Buffers single-cycle ISA capture records in a small FIFO and serialises each
// one as an 11-byte framed stream (header, mask, addr, data, XOR checksum).
module isa_record_packer #(
    parameter int          DEPTH = 8,
    parameter logic [7:0]  HDR   = 8'hA5
) (
    input  logic        clk_rd,
    input  logic        rstn,
    input  logic [31:0] isa_addr_i,
    input  logic [31:0] isa_data_i,
    input  logic [3:0]  isa_mask_i,
    input  logic        isa_valid_i,
    output logic        isa_tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [67:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic [67:0]   r_frame;
    logic [7:0]    r_csum;
    logic [3:0]    r_byte_idx;

    logic [67:0]   w_head;
    logic          w_pop;
    logic          w_push;
    logic          w_hs;
    logic [CW-1:0] w_count_nxt;
    logic [7:0]    w_next_byte;

    // Record layout is {mask, addr, data}; the checksum covers frame bytes 1..9.
    function automatic logic [7:0] frame_csum(input logic [67:0] f);
        return {4'h0, f[67:64]} ^ f[63:56] ^ f[55:48] ^ f[47:40] ^ f[39:32]
             ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [67:0] f,
                                              input logic [7:0]  cs);
        case (idx)
            4'd0:    return HDR;
            4'd1:    return {4'h0, f[67:64]};
            4'd2:    return f[63:56];
            4'd3:    return f[55:48];
            4'd4:    return f[47:40];
            4'd5:    return f[39:32];
            4'd6:    return f[31:24];
            4'd7:    return f[23:16];
            4'd8:    return f[15:8];
            4'd9:    return f[7:0];
            default: return cs;
        endcase
    endfunction

    assign w_head      = r_mem[r_rd_ptr];
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign w_push      = isa_valid_i && ((r_count < CW'(DEPTH)) || w_pop);
    assign w_hs        = tx_valid && tx_ready;
    assign w_next_byte = frame_byte(r_byte_idx + 4'd1, r_frame, r_csum);

    // NOTE: every variable driven in always_comb gets a default first, so no latch can form.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_count_nxt = r_count - CW'(1);
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk_rd) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {isa_mask_i, isa_addr_i, isa_data_i};
    end

    // NOTE: all state updates use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk_rd or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            isa_tx_ready <= 1'b1;
            drop_cnt     <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count      <= w_count_nxt;
            isa_tx_ready <= (w_count_nxt <= CW'(DEPTH - 2));
            if (isa_valid_i && !w_push && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // The shadow register is loaded only at the pop, isolating the frame in flight.
    always_ff @(posedge clk_rd or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_csum     <= '0;
            r_byte_idx <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_frame    <= w_head;
                        r_csum     <= frame_csum(w_head);
                        r_byte_idx <= '0;
                        tx_data    <= HDR;
                        tx_valid   <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (r_byte_idx == 4'd10) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            tx_data    <= w_next_byte;
                        end
                    end
                end
            endcase
        end
    end

endmodule
